// File: rtl/pwm_capture.sv
// PWM receiver: synchronises pwm_in, measures high time per 2^PWM_BITS-cycle
// period, flags bad period lengths and stuck inputs, and reports the recovered duty.
module pwm_capture #(
  parameter int PWM_BITS = 16,
  parameter int ERR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [PWM_BITS-1:0] duty,
  output logic                duty_valid,
  output logic                locked,
  output logic                stuck_high,
  output logic                stuck_low,
  output logic [ERR_BITS-1:0] err_cnt
);

  localparam int CW = PWM_BITS + 1;
  localparam logic [CW-1:0]       CNT_ONE = {{PWM_BITS{1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_NOM = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [CW-1:0]       CNT_MAX = '1;
  localparam logic [ERR_BITS-1:0] ERR_ONE = {{(ERR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic          rise, lvl;
  logic [CW-1:0] per_cnt, hi_cnt;

  assign rise = s2 & ~s3;
  assign lvl  = s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      s1         <= pwm_in;
      s2         <= s1;
      s3         <= s2;
      duty_valid <= 1'b0;

      // Counters saturate at their maximum so per_cnt can never wrap.
      if (rise) begin
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + CNT_ONE;
        hi_cnt  <= hi_cnt + {{PWM_BITS{1'b0}}, lvl};
      end

      case (state)
        IDLE, MEASURE: begin
          if (rise) begin
            if (state == MEASURE) begin
              if (per_cnt == CNT_NOM) begin
                duty       <= hi_cnt[PWM_BITS-1:0];
                duty_valid <= 1'b1;
                locked     <= 1'b1;
              end else begin
                locked <= 1'b0;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
              end
            end
            state <= MEASURE;
          end else if (per_cnt == CNT_MAX) begin
            state      <= STUCK;
            locked     <= 1'b0;
            duty_valid <= 1'b1;
            if (lvl) begin
              stuck_high <= 1'b1;
              duty       <= '1;
            end else begin
              stuck_low <= 1'b1;
              duty      <= '0;
            end
          end
        end
        STUCK: begin
          if (rise) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
            state      <= MEASURE;
          end else if (stuck_high && !lvl && !duty_valid) begin
            // Level-based so a fall right after stuck entry is taken one cycle
            // later instead of producing back-to-back duty_valid pulses.
            stuck_high <= 1'b0;
            stuck_low  <= 1'b1;
            duty       <= '0;
            duty_valid <= 1'b1;
            per_cnt    <= CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (PWM_BITS=4): directed and random PWM streams checked
// every cycle against a period-window reference model.
module tb_pwm_capture;

  localparam int PB      = 4;
  localparam int PERIOD  = 1 << PB;
  localparam int TIMEOUT = 2 * PERIOD - 1;

  logic          clk;
  logic          rst_n;
  logic          pwm_in;
  logic [PB-1:0] duty;
  logic          duty_valid;
  logic          locked;
  logic          stuck_high;
  logic          stuck_low;
  logic [7:0]    err_cnt;

  pwm_capture #(.PWM_BITS(PB), .ERR_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .duty(duty), .duty_valid(duty_valid), .locked(locked),
    .stuck_high(stuck_high), .stuck_low(stuck_low), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: hist holds the synchronised level stream (two leading
  // zeros stand for the cleared sync flops); periods are rise-to-rise windows.
  bit       hist[$];
  bit       wave[$];
  int       m_k, m_last_rise, m_mode;  // mode: 0 idle, 1 measuring, 2 stuck
  bit [3:0] m_duty;
  bit [7:0] m_err;
  bit       m_valid, m_locked, m_sh, m_sl;

  function automatic void model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_k = 0; m_last_rise = 0; m_mode = 0;
    m_duty = '0; m_err = '0;
    m_valid = 0; m_locked = 0; m_sh = 0; m_sl = 0;
  endfunction

  function automatic void model_process();
    bit x, p, rise, pv;
    int per, h;
    x    = hist[m_k];
    p    = (m_k > 0) ? hist[m_k-1] : 1'b0;
    rise = x && !p;
    per  = m_k - m_last_rise;
    pv   = m_valid;
    m_valid = 0;
    if (m_mode == 2) begin
      if (rise) begin
        m_sh = 0; m_sl = 0; m_mode = 1; m_last_rise = m_k;
      end else if (m_sh && !x && !pv) begin
        m_sh = 0; m_sl = 1; m_duty = '0; m_valid = 1; m_last_rise = m_k;
      end
    end else if (rise) begin
      if (m_mode == 1) begin
        if (per == PERIOD) begin
          h = 0;
          for (int j = m_last_rise; j < m_k; j++) h += int'(hist[j]);
          m_duty   = 4'(h % PERIOD);
          m_valid  = 1;
          m_locked = 1;
        end else begin
          m_locked = 0;
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
      m_mode = 1;
      m_last_rise = m_k;
    end else if (per == TIMEOUT) begin
      m_mode = 2; m_locked = 0; m_valid = 1;
      if (x) begin m_sh = 1; m_duty = '1; end
      else begin m_sl = 1; m_duty = '0; end
    end
    m_k++;
  endfunction

  function automatic logic [16:0] obs();
    return {duty, duty_valid, locked, stuck_high, stuck_low, err_cnt};
  endfunction

  function automatic logic [16:0] expv();
    return {m_duty, m_valid, m_locked, m_sh, m_sl, m_err};
  endfunction

  function automatic void add_period(input int len, input int h);
    for (int i = 0; i < len; i++) wave.push_back(i < h);
  endfunction

  function automatic void add_run(input bit lvl, input int n);
    for (int i = 0; i < n; i++) wave.push_back(lvl);
  endfunction

  // Drive one input bit, advance one clock, sample on the falling edge.
  task automatic step(input bit b);
    pwm_in = b;
    hist.push_back(b);
    @(posedge clk);
    model_process();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (obs() !== 17'h0) begin
      miscompares++; $display("FAIL reset_initial got %h exp %h", obs(), 17'h0);
    end
    repeat (3) begin @(negedge clk); pwm_in = ~pwm_in; end
    vectors++;
    if (obs() !== 17'h0) begin
      miscompares++; $display("FAIL reset_held got %h exp %h", obs(), 17'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL reset_release cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_good_periods();
    int pulses = 0;
    apply_reset();
    wave.delete();
    add_run(0, 4);
    repeat (3) add_period(16, 5);
    add_run(1, 4);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      pulses += int'(duty_valid);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL good_periods cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({duty, locked, err_cnt, 32'(pulses)} !== {4'd5, 1'b1, 8'd0, 32'd3}) begin
      miscompares++;
      $display("FAIL good_summary duty=%0d locked=%0d err=%0d pulses=%0d exp 5 1 0 3",
               duty, locked, err_cnt, pulses);
    end
  endtask

  task automatic test_duty_change();
    int pulses = 0;
    apply_reset();
    wave.delete();
    add_run(0, 4);
    repeat (2) add_period(16, 5);
    repeat (2) add_period(16, 12);
    add_run(1, 4);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      pulses += int'(duty_valid);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL duty_change cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({duty, 32'(pulses)} !== {4'd12, 32'd4}) begin
      miscompares++;
      $display("FAIL duty_change_summary duty=%0d pulses=%0d exp 12 4", duty, pulses);
    end
  endtask

  task automatic test_bad_periods();
    apply_reset();
    wave.delete();
    add_run(0, 4);
    add_period(16, 5); add_period(16, 5); add_period(15, 5);
    add_period(16, 5); add_period(17, 5); add_period(16, 6);
    add_run(1, 4);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL bad_periods cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({duty, locked, err_cnt} !== {4'd6, 1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL bad_summary duty=%0d locked=%0d err=%0d exp 6 1 2", duty, locked, err_cnt);
    end
  endtask

  task automatic test_stuck_high();
    apply_reset();
    wave.delete();
    add_run(0, 4);
    repeat (2) add_period(16, 5);
    add_run(1, 40);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL stuck_high cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({stuck_high, stuck_low, duty, locked} !== {1'b1, 1'b0, 4'd15, 1'b0}) begin
      miscompares++;
      $display("FAIL stuck_high_flag sh=%0d sl=%0d duty=%0d locked=%0d exp 1 0 15 0",
               stuck_high, stuck_low, duty, locked);
    end
    wave.delete();
    add_run(0, 13);
    repeat (2) add_period(16, 3);
    add_run(1, 4);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL stuck_recover cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({stuck_high, stuck_low, duty, locked, err_cnt} !== {1'b0, 1'b0, 4'd3, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL stuck_recover_summary sh=%0d sl=%0d duty=%0d locked=%0d err=%0d exp 0 0 3 1 0",
               stuck_high, stuck_low, duty, locked, err_cnt);
    end
  endtask

  task automatic test_stuck_low();
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      pulses += int'(duty_valid);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL stuck_low cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({stuck_low, stuck_high, duty, err_cnt, 32'(pulses)} !== {1'b1, 1'b0, 4'd0, 8'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL stuck_low_summary sl=%0d sh=%0d duty=%0d err=%0d pulses=%0d exp 1 0 0 0 1",
               stuck_low, stuck_high, duty, err_cnt, pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    apply_reset();
    wave.delete();
    add_run(0, 4);
    repeat (3) add_period(16, 7);
    add_run(1, 3);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL pre_reset cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({duty, locked} !== {4'd7, 1'b1}) begin
      miscompares++; $display("FAIL pre_reset_state duty=%0d locked=%0d exp 7 1", duty, locked);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 17'h0) begin
      miscompares++; $display("FAIL async_reset got %h exp %h", obs(), 17'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wave.delete();
    add_run(0, 2);
    repeat (2) add_period(16, 7);
    add_run(1, 3);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      pulses += int'(duty_valid);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL post_reset cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
    vectors++;
    if ({duty, locked, 32'(pulses)} !== {4'd7, 1'b1, 32'd2}) begin
      miscompares++;
      $display("FAIL post_reset_summary duty=%0d locked=%0d pulses=%0d exp 7 1 2", duty, locked, pulses);
    end
  endtask

  task automatic test_random();
    int r, len;
    apply_reset();
    wave.delete();
    add_run(0, 3);
    for (int e = 0; e < 120; e++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        add_period(PERIOD, int'($urandom_range(1, PERIOD - 1)));
      end else if (r < 85) begin
        len = int'($urandom_range(2, 24));
        if (len == PERIOD) len = PERIOD + 1;
        add_period(len, int'($urandom_range(1, len - 1)));
      end else if (r < 93) begin
        add_run(1, int'($urandom_range(28, 45)));
        add_run(0, int'($urandom_range(1, 20)));
      end else begin
        add_run(0, int'($urandom_range(28, 45)));
      end
    end
    add_run(1, 3);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL random cyc %0d got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    pwm_in      = 1'b0;
    model_reset();
    test_reset();
    test_good_periods();
    test_duty_change();
    test_bad_periods();
    test_stuck_high();
    test_stuck_low();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiver for the 2^PWM_BITS-cycle PWM stream produced by the top-level PWM output stage.
- Synchronises an external PWM input, measures high time per period, and validates that the period length is exactly 2^PWM_BITS clk cycles.
- Reports the recovered duty value, so the DSP/PWM chain can be checked in hardware (loopback on the board) and shown on the hex displays.

Parameters:
- PWM_BITS, 16, duty/period resolution; nominal period = 2^PWM_BITS clk cycles.
- ERR_BITS, 8, width of saturating period-error counter.

Ports:
- clk  input  1  system clock (same clock domain as the PWM generator's fast clock).
- rst_n  input  1  reset, asynchronous, active-low.
- pwm_in  input  1  PWM signal, asynchronous to clk.
- duty  output  PWM_BITS  last recovered high-cycle count.
- duty_valid  output  1  one-cycle pulse when duty is updated.
- locked  output  1  last measured period had the nominal length.
- stuck_high  output  1  input has stayed high for 2^(PWM_BITS+1)-1 cycles or more.
- stuck_low  output  1  input has stayed low for 2^(PWM_BITS+1)-1 cycles or more.
- err_cnt  output  ERR_BITS  count of bad-length periods, saturating.

Behaviour:
- Reset (async, rst_n=0): all flops 0.
  - Outputs: duty=0, duty_valid=0, locked=0, stuck_high=0, stuck_low=0, err_cnt=0.
  - State goes to IDLE.
- Input path:
  - s1 <= pwm_in; s2 <= s1; s3 <= s2.
  - rise = s2 & ~s3, combinational.
  - Level lvl = s2.
- Counters, both PWM_BITS+1 bits wide:
  - per_cnt counts cycles since the last rise.
  - hi_cnt counts cycles with lvl=1 since the last rise.
  - On a rise cycle: per_cnt <= 1, hi_cnt <= 1.
  - Otherwise: per_cnt <= per_cnt+1, hi_cnt <= hi_cnt+lvl.
  - per_cnt never wraps; the STUCK transition happens first.
- FSM states: IDLE, MEASURE, STUCK.
- IDLE:
  - Counters run, no outputs change.
  - rise -> MEASURE. The first partial period is discarded.
  - per_cnt == 2^(PWM_BITS+1)-1 -> STUCK.
- MEASURE, on rise:
  - Good period (old per_cnt == 2^PWM_BITS): duty <= old hi_cnt[PWM_BITS-1:0]; duty_valid <= 1; locked <= 1.
  - Bad period (any other length): locked <= 0; err_cnt <= err_cnt+1, saturating at all-ones; duty unchanged; no duty_valid.
  - Stay in MEASURE.
- MEASURE, per_cnt == 2^(PWM_BITS+1)-1 without a rise -> STUCK. On entry:
  - locked <= 0.
  - If lvl=1: stuck_high <= 1, duty <= all-ones.
  - If lvl=0: stuck_low <= 1, duty <= 0.
  - duty_valid <= 1 for one cycle. Stuck entry does not increment err_cnt.
- STUCK:
  - per_cnt holds at its maximum.
  - On rise: clear stuck_high and stuck_low, reload counters as for a rise, go to MEASURE. That first period is measured normally.
  - If lvl changes without a rise (high to low while stuck_high): swap to stuck_low=1, stuck_high=0, duty <= 0, pulse duty_valid, and reload per_cnt so the stuck timeout restarts. Low to high always produces a rise.
- Latency:
  - duty_valid is registered and rises 3 clk edges after the pwm_in rising edge that closes the period (2 sync stages plus 1 output register).
  - duty_valid is never high on two consecutive cycles.
- Duty semantics:
  - 0 = stuck low; all-ones = stuck high.
  - Otherwise duty = number of high cycles in the period.
  - This matches the generator's encoding: val=0 gives constant low, val=all-ones gives constant high.
- Simultaneous events: rise takes priority over timeout in the same cycle.
- Reset mid-period: everything clears immediately and the next period after the first rise is measured from scratch.

Test Plan (run with PWM_BITS=4, period 16):
- Reset, then a 16-cycle period with 5 cycles high, repeated 3 times -> first rise gives nothing; then duty=5 with one duty_valid pulse per period, 3 clk after each rise; locked=1; err_cnt=0.
- Duty change 5 -> 12 across a period boundary -> duty goes 5 then 12, each value valid exactly once per period; no glitch pulses.
- Periods of 15 then 17 cycles injected between good ones -> err_cnt increments 1, then 2; locked=0 after each bad period and returns to 1 on the next good one; duty holds its last good value.
- pwm_in held high for 40 cycles -> stuck_high=1 and duty=15 with one duty_valid after 31 cycles with no rise; then normal 3-high PWM -> stuck cleared, duty=3 after the first full period.
- pwm_in held low from reset for 31 cycles -> stuck_low=1, duty=0, duty_valid once; err_cnt=0.
- Assert rst_n low mid-period with duty=7 and locked=1 -> all outputs 0 asynchronously; after release the first rise produces no valid; the next good period gives duty=7.
